// File: rtl/logic_gate_pkg.sv
// Shared opcode encoding for the registered logic unit and anything that drives it.
package logic_gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOT  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;

endpackage

// File: rtl/logic_gate_unit_if.sv
// Operand/result bundle for logic_gate_unit; master drives operands, slave returns results.
interface logic_gate_unit_if #(
  parameter int WIDTH = 1
);
  import logic_gate_pkg::*;

  // Handshake: in_valid qualifies a/b/op for exactly the cycle it is high. There is no
  // ready, so every valid cycle is accepted. out_valid is high for one cycle per accept.
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             out_valid;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_or;
  logic [WIDTH-1:0] y_not;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_nor;
  logic [WIDTH-1:0] y_sel;

  modport master (
    output in_valid, a, b, op,
    input  out_valid, y_and, y_or, y_not, y_nand, y_nor, y_sel
  );

  modport slave (
    input  in_valid, a, b, op,
    output out_valid, y_and, y_or, y_not, y_nand, y_nor, y_sel
  );

endinterface

// File: rtl/logic_gate_unit_cells.sv
// Combinational leaf gates used by logic_gate_unit; all are plain per-bit functions.
module and_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module nand_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a & b);
endmodule

module nor_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/logic_gate_unit.sv
// Registered two-operand bitwise logic unit: all gate results plus an opcode-selected one,
// one cycle after operand capture.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic            clk,
  input logic            rst_n,
  logic_gate_unit_if.slave bus
);

  logic [WIDTH-1:0] and_w, nand_w, nor_w, not_w, or_w, sel_w;
  logic             valid_q;
  logic [WIDTH-1:0] and_q, or_q, not_q, nand_q, nor_q, sel_q;

  and_gate  #(.WIDTH(WIDTH)) u_and  (.a(bus.a), .b(bus.b), .y(and_w));
  nand_gate #(.WIDTH(WIDTH)) u_nand (.a(bus.a), .b(bus.b), .y(nand_w));
  nor_gate  #(.WIDTH(WIDTH)) u_nor  (.a(bus.a), .b(bus.b), .y(nor_w));
  // NOT is a NAND with both inputs tied to a; OR is the inverted NOR.
  nand_gate #(.WIDTH(WIDTH)) u_not  (.a(bus.a), .b(bus.a), .y(not_w));
  assign or_w = ~nor_w;

  always_comb begin
    sel_w = '0;
    case (bus.op)
      OP_AND:  sel_w = and_w;
      OP_OR:   sel_w = or_w;
      OP_NOT:  sel_w = not_w;
      OP_NAND: sel_w = nand_w;
      OP_NOR:  sel_w = nor_w;
      default: sel_w = '0;
    endcase
  end

  // Results only load on accept, so undriven operands during idle cycles never reach outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      and_q   <= '0;
      or_q    <= '0;
      not_q   <= '0;
      nand_q  <= '0;
      nor_q   <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        and_q  <= and_w;
        or_q   <= or_w;
        not_q  <= not_w;
        nand_q <= nand_w;
        nor_q  <= nor_w;
        sel_q  <= sel_w;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.y_and     = and_q;
  assign bus.y_or      = or_q;
  assign bus.y_not     = not_q;
  assign bus.y_nand    = nand_q;
  assign bus.y_nor     = nor_q;
  assign bus.y_sel     = sel_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: a 1-bit and an 8-bit instance share clock and reset.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic_gate_unit_if #(.WIDTH(1)) bus1 ();
  logic_gate_unit_if #(.WIDTH(8)) bus8 ();

  logic_gate_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  logic_gate_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  // Packed as {out_valid, y_and, y_or, y_not, y_nand, y_nor, y_sel}.
  logic [6:0]  exp1_q[$];
  logic [48:0] exp8_q[$];
  logic [6:0]  m1, exp1, obs1;
  logic [48:0] m8, exp8, obs8;
  // Truth table rows {AND, OR, NOT, NAND, NOR}, indexed by {a, b}.
  logic [4:0]  tt [4] = '{5'b00111, 5'b01110, 5'b01010, 5'b11000};

  assign obs1 = {bus1.out_valid, bus1.y_and, bus1.y_or, bus1.y_not, bus1.y_nand, bus1.y_nor, bus1.y_sel};
  assign obs8 = {bus8.out_valid, bus8.y_and, bus8.y_or, bus8.y_not, bus8.y_nand, bus8.y_nor, bus8.y_sel};

  function automatic logic [48:0] model8(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [7:0] sel;
    case (op)
      3'd0:    sel = a & b;
      3'd1:    sel = a | b;
      3'd2:    sel = ~a;
      3'd3:    sel = ~(a & b);
      3'd4:    sel = ~(a | b);
      default: sel = 8'h00;
    endcase
    return {1'b1, a & b, a | b, ~a, ~(a & b), ~(a | b), sel};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic v, input logic [1:0] ab);
    bus1.in_valid = v;
    bus1.a        = ab[1];
    bus1.b        = ab[0];
    bus1.op       = OP_AND;
    if (v) m1 = {1'b1, tt[ab], tt[ab][4]};
    else   m1[6] = 1'b0;
    exp1_q.push_back(m1);
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus8.in_valid = v;
    bus8.a        = a;
    bus8.b        = b;
    bus8.op       = op;
    if (v) m8 = model8(a, b, op);
    else   m8[48] = 1'b0;
    exp8_q.push_back(m8);
  endtask

  task automatic model_reset();
    m1 = '0;
    m8 = '0;
    exp1_q.delete();
    exp8_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.op = OP_AND;
    bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00; bus8.op = OP_NOR;
    #2 rst_n = 1'b0;
    #1;
    tests_run += 2;
    if (obs1 !== 7'h00) begin tests_failed++; $display("FAIL reset_async w1: got %b want %b", obs1, 7'h00); end
    if (obs8 !== 49'h0) begin tests_failed++; $display("FAIL reset_async w8: got %h want %h", obs8, 49'h0); end
    // Valid inputs across an edge must not load while reset is held.
    @(posedge clk); #1;
    tests_run += 2;
    if (obs1 !== 7'h00) begin tests_failed++; $display("FAIL reset_hold w1: got %b want %b", obs1, 7'h00); end
    if (obs8 !== 49'h0) begin tests_failed++; $display("FAIL reset_hold w8: got %h want %h", obs8, 49'h0); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b0, 2'b00);
    drive8(1'b0, 8'h00, 8'h00, OP_AND);
    @(posedge clk); #1;
    exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
    if (obs1 !== exp1) begin tests_failed++; $display("FAIL reset_release w1: got %b want %b", obs1, exp1); end
    if (obs8 !== exp8) begin tests_failed++; $display("FAIL reset_release w8: got %h want %h", obs8, exp8); end
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b1, 2'(i));
      drive8(1'b0, 8'h00, 8'h00, OP_AND);
      @(posedge clk); #1;
      exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
      if (obs1 !== exp1) begin tests_failed++; $display("FAIL truth_table ab=%0d w1: got %b want %b", i, obs1, exp1); end
      if (obs8 !== exp8) begin tests_failed++; $display("FAIL truth_table_idle w8: got %h want %h", obs8, exp8); end
    end
  endtask

  task automatic test_opcode_sweep();
    for (int op = 0; op < 8; op++) begin
      @(negedge clk);
      drive1(1'b0, 2'b00);
      drive8(1'b1, 8'hC5, 8'h3A, 3'(op));
      @(posedge clk); #1;
      exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
      if (obs8 !== exp8) begin tests_failed++; $display("FAIL opcode_sweep op=%0d w8: got %h want %h", op, obs8, exp8); end
      if (obs1 !== exp1) begin tests_failed++; $display("FAIL opcode_sweep_idle w1: got %b want %b", obs1, exp1); end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive1(1'b0, 2'b00);
    drive8(1'b1, 8'hF0, 8'h0F, OP_OR);
    @(posedge clk); #1;
    exp8 = exp8_q.pop_front(); void'(exp1_q.pop_front()); tests_run++;
    if (obs8 !== exp8) begin tests_failed++; $display("FAIL hold_accept w8: got %h want %h", obs8, exp8); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive1(1'b0, 2'b11);
      drive8(1'b0, 8'h00, 8'hxx, 3'bxxx);
      @(posedge clk); #1;
      exp8 = exp8_q.pop_front(); exp1 = exp1_q.pop_front(); tests_run += 2;
      if (obs8 !== exp8) begin tests_failed++; $display("FAIL hold cyc=%0d w8: got %h want %h", i, obs8, exp8); end
      if (obs1 !== exp1) begin tests_failed++; $display("FAIL hold cyc=%0d w1: got %b want %b", i, obs1, exp1); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive1(1'b1, 2'b00);
    drive8(1'b1, 8'h00, 8'h00, OP_NOR);
    @(posedge clk); #1;
    exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
    if (obs1 !== exp1) begin tests_failed++; $display("FAIL areset_accept w1: got %b want %b", obs1, exp1); end
    if (obs8 !== exp8) begin tests_failed++; $display("FAIL areset_accept w8: got %h want %h", obs8, exp8); end
    #2 rst_n = 1'b0;
    #1;
    tests_run += 2;
    if (obs1 !== 7'h00) begin tests_failed++; $display("FAIL areset_mid w1: got %b want %b", obs1, 7'h00); end
    if (obs8 !== 49'h0) begin tests_failed++; $display("FAIL areset_mid w8: got %h want %h", obs8, 49'h0); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive1(1'b0, 2'b11);
    drive8(1'b0, 8'hAA, 8'h55, OP_OR);
    @(posedge clk); #1;
    exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
    if (obs1 !== exp1) begin tests_failed++; $display("FAIL areset_idle w1: got %b want %b", obs1, exp1); end
    if (obs8 !== exp8) begin tests_failed++; $display("FAIL areset_idle w8: got %h want %h", obs8, exp8); end
    @(negedge clk);
    drive1(1'b1, 2'b10);
    drive8(1'b1, 8'h96, 8'h0F, OP_NAND);
    @(posedge clk); #1;
    exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
    if (obs1 !== exp1) begin tests_failed++; $display("FAIL areset_reaccept w1: got %b want %b", obs1, exp1); end
    if (obs8 !== exp8) begin tests_failed++; $display("FAIL areset_reaccept w8: got %h want %h", obs8, exp8); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive1(1'b1, 2'(i));
      drive8(1'b1, {4{2'(i)}}, {4{2'(3 - i)}}, 3'(i));
      @(posedge clk); #1;
      exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
      if (obs1 !== exp1) begin tests_failed++; $display("FAIL back_to_back i=%0d w1: got %b want %b", i, obs1, exp1); end
      if (obs8 !== exp8) begin tests_failed++; $display("FAIL back_to_back i=%0d w8: got %h want %h", i, obs8, exp8); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive1(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      drive8(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             3'($urandom_range(0, 7)));
      @(posedge clk); #1;
      exp1 = exp1_q.pop_front(); exp8 = exp8_q.pop_front(); tests_run += 2;
      if (obs1 !== exp1) begin tests_failed++; $display("FAIL random i=%0d w1: got %b want %b", i, obs1, exp1); end
      if (obs8 !== exp8) begin tests_failed++; $display("FAIL random i=%0d w8: got %h want %h", i, obs8, exp8); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m1 = '0;
    m8 = '0;
    test_reset();
    test_truth_table();
    test_opcode_sweep();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Registered two-operand bitwise logic unit. Computes AND, OR, NOT, NAND and NOR of two WIDTH-bit operands, plus one opcode-selected result, and registers all results on a single clock. It serves as the basic logic primitive stage for datapath blocks that need all gate results one cycle after operand capture.

## Interface
- WIDTH, default 1: operand and result width in bits (legal range 1 to 64).
- clk  input  1  rising-edge clock, the only clock in the block.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operands a, b and op are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  selects the y_sel result: 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5–7 reserved.
- out_valid  output  1  results below correspond to the last accepted operands.
- y_and  output  WIDTH  registered a & b.
- y_or  output  WIDTH  registered a | b.
- y_not  output  WIDTH  registered ~a (b ignored).
- y_nand  output  WIDTH  registered ~(a & b).
- y_nor  output  WIDTH  registered ~(a | b).
- y_sel  output  WIDTH  registered result chosen by op.

## Operation
- All functions are bitwise and independent per bit. There is no carry and no inter-bit dependency.
- Accept: on a rising clk edge with in_valid=1, all six result registers load the functions of the current a, b and op. out_valid is set to 1.
- Hold: on a rising clk edge with in_valid=0, all result registers keep their values. out_valid drops to 0.
- Reserved op values (5–7) load y_sel with all zeros. The other five outputs are unaffected by op.
- X or Z on a, b or op while in_valid=0 must not change any output.

## Timing
- Latency: exactly 1 cycle. Operands sampled at edge N appear on the outputs after edge N.
- Throughput: one operand set per cycle. There is no backpressure and no ready signal.
- Reset: while rst_n=0, all outputs are forced to 0 immediately, without waiting for clk. This includes y_nand and y_nor, and out_valid=0.
- Reset release: the first accept can occur on the first rising edge after rst_n goes high.
- Reset asserted mid-stream: any pending result is discarded. Outputs are 0 until the next accept.
- in_valid=1 on consecutive cycles: each edge overwrites the results with no bubble.
- All outputs come directly from flops. No combinational path exists from inputs to outputs.

## Structure
- Shared package logic_gate_pkg contains:
  - the 3-bit opcode localparams OP_AND, OP_OR, OP_NOT, OP_NAND, OP_NOR;
  - the op_t typedef.
- Leaf cells are and_gate, nand_gate and nor_gate: combinational, WIDTH-parameterized, ports (a, b, y).
- OR is derived as the inversion of the nor_gate output, and NOT as nand_gate(a, a).
- The top level instantiates the leaf cells, the y_sel mux and the result/valid registers.

## Test plan
- Truth table, WIDTH=1, in_valid=1, op=0: apply ab=00, 01, 10, 11 on successive cycles. Required outputs one cycle later, listed in the order AND OR NOT NAND NOR:
  - ab=00 → 0 0 1 1 1
  - ab=01 → 0 1 1 1 0
  - ab=10 → 0 1 0 1 0
  - ab=11 → 1 1 0 0 0
- Opcode sweep, WIDTH=8, a=8'hC5, b=8'h3A:
  - op=0 → y_sel=00
  - op=1 → y_sel=FF
  - op=2 → y_sel=3A
  - op=3 → y_sel=FF
  - op=4 → y_sel=00
  - op=5, 6, 7 → y_sel=00
- Hold: accept a=8'hF0, b=8'h0F, then drive in_valid=0 with a=8'h00 for 3 cycles. Required: y_or stays FF, y_and stays 00, out_valid=0.
- Async reset: assert rst_n=0 between clock edges after an accept with ab=00. Required: y_nand, y_nor, y_not and out_valid go to 0 before the next edge and stay 0 until the first accept after release.
- Back-to-back: drive 4 consecutive accepts ab=00, 01, 10, 11. Required: out_valid stays 1 for 4 cycles, and the results match the truth table exactly one cycle behind the inputs.
